// File: rtl/fp_pkg.sv
// Shared single-precision field layout, constants and arbiter state encoding
// for the shared FP add/subtract datapath.
package fp_pkg;

    localparam int unsigned FP_W  = 32;
    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAN_W = 23;

    localparam logic [FP_W-1:0] FP_POS_INF = 32'h7F800000;
    localparam logic [FP_W-1:0] FP_QNAN    = 32'h7FC00000;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } arb_state_t;

    function automatic logic fp_is_nan(input fp_t x);
        return (x.exp == '1) && (x.man != '0);
    endfunction

    function automatic logic fp_is_inf(input fp_t x);
        return (x.exp == '1) && (x.man == '0);
    endfunction

endpackage

// File: rtl/fp_addsub_arbiter_add.sv
// Combinational IEEE-754 single-precision add/subtract, round-to-nearest-even,
// with subnormal, infinity and NaN handling (NaN results are the quiet 0x7FC00000).
module fp_add
    import fp_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    input  logic            sub,
    output logic [FP_W-1:0] y
);

    // hidden bit + mantissa + guard/round/sticky
    localparam int unsigned XW = MAN_W + 4;

    fp_t              fa, fb, big, sml;
    logic             a_nan, b_nan, a_inf, b_inf;
    logic [EXP_W:0]   eb, es, dexp, e, sh;
    logic [MAN_W:0]   mb, ms;
    logic [XW-1:0]    mb_x, ms_x, ms_sh, m, diff;
    logic [XW:0]      sum;
    logic [4:0]       lz;
    logic [EXP_W-1:0] ef;
    logic             rnd;
    logic [FP_W-2:0]  mag;

    always_comb begin
        fa      = a;
        fb      = b;
        fb.sign = b[FP_W-1] ^ sub;
        a_nan   = fp_is_nan(fa);
        b_nan   = fp_is_nan(fb);
        a_inf   = fp_is_inf(fa);
        b_inf   = fp_is_inf(fb);

        if ({fb.exp, fb.man} > {fa.exp, fa.man}) begin
            big = fb;
            sml = fa;
        end else begin
            big = fa;
            sml = fb;
        end

        // subnormals share the minimum normal exponent, without the hidden bit
        eb   = (big.exp == '0) ? (EXP_W+1)'(1) : {1'b0, big.exp};
        es   = (sml.exp == '0) ? (EXP_W+1)'(1) : {1'b0, sml.exp};
        mb   = {big.exp != '0, big.man};
        ms   = {sml.exp != '0, sml.man};
        dexp = eb - es;
        mb_x = {mb, 3'b000};
        ms_x = {ms, 3'b000};

        if (dexp >= (EXP_W+1)'(XW)) begin
            ms_sh    = '0;
            ms_sh[0] = |ms;
        end else begin
            ms_sh    = ms_x >> dexp;
            ms_sh[0] = ms_sh[0] | (|(ms_x & ~({XW{1'b1}} << dexp)));
        end

        sum  = '0;
        diff = '0;
        lz   = '0;
        sh   = '0;
        m    = '0;
        e    = eb;
        if (big.sign == sml.sign) begin
            sum = {1'b0, mb_x} + {1'b0, ms_sh};
            if (sum[XW]) begin
                m    = sum[XW:1];
                m[0] = sum[1] | sum[0];
                e    = eb + 1'b1;
            end else begin
                m = sum[XW-1:0];
            end
        end else begin
            diff = mb_x - ms_sh;
            lz   = 5'(XW);
            for (int unsigned i = 0; i < XW; i++) begin
                if (diff[i]) begin
                    lz = 5'(XW - 1 - i);
                end
            end
            // normalise, but never below the minimum exponent (subnormal result)
            sh = ({4'b0000, lz} > (eb - 1'b1)) ? (eb - 1'b1) : {4'b0000, lz};
            m  = diff << sh;
            e  = eb - sh;
        end

        // rounding carry ripples into the exponent field, including to infinity
        ef  = m[XW-1] ? e[EXP_W-1:0] : {EXP_W{1'b0}};
        rnd = m[2] & (m[1] | m[0] | m[3]);
        mag = {ef, m[XW-2:3]} + (FP_W-1)'(rnd);

        if (a_nan || b_nan || (a_inf && b_inf && (fa.sign != fb.sign))) begin
            y = FP_QNAN;
        end else if (a_inf) begin
            y = fa;
        end else if (b_inf) begin
            y = fb;
        end else if ((big.sign != sml.sign) && (diff == '0)) begin
            y = '0;
        end else if (e >= {1'b0, {EXP_W{1'b1}}}) begin
            y = {big.sign, FP_POS_INF[FP_W-2:0]};
        end else begin
            y = {big.sign, mag};
        end
    end

endmodule

// File: rtl/fp_addsub_arbiter_rr.sv
// Round-robin grant: first asserted request at or after ptr, wrapping;
// produces a one-hot grant, its index and an any-request flag.
module rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        int unsigned jw;
        logic [IW-1:0] j;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        jw  = 0;
        j   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            jw = 32'(ptr) + k;
            if (jw >= N) begin
                jw = jw - N;
            end
            j = IW'(jw);
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = j;
            end
        end
    end

endmodule

// File: rtl/fp_addsub_arbiter.sv
// Round-robin sequencer sharing one FP add/subtract datapath among NUM_REQ clients.
// Optional FP_ARB_FLAGS_EN adds a registered rsp_flags = {nan, inf} output.
module fp_addsub_arbiter
    import fp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]            req_symbol,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          busy
`ifdef FP_ARB_FLAGS_EN
    ,
    output logic [1:0]                    rsp_flags
`endif
);

    arb_state_t            state;
    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       gidx;
    logic [NUM_REQ-1:0]    gnt;
    logic                  gany;
    logic                  grant_en;
    logic                  accept;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic                  op_sub;
    logic [ID_W-1:0]       op_id;
    logic [DATA_WIDTH-1:0] add_y;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_arb (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (gidx),
        .any (gany)
    );

    fp_add u_add (
        .a   (op_a),
        .b   (op_b),
        .sub (op_sub),
        .y   (add_y)
    );

`ifdef FP_ARB_FLAGS_EN
    fp_t add_f;
    assign add_f = add_y;
`endif

    // a grant is offered in IDLE, or in RESP in the same cycle the response retires
    always_comb begin
        grant_en  = !rst && ((state == IDLE) || ((state == RESP) && rsp_ready));
        accept    = grant_en && gany;
        req_ready = grant_en ? gnt : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_sub    <= 1'b0;
            op_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            busy      <= 1'b0;
`ifdef FP_ARB_FLAGS_EN
            rsp_flags <= '0;
`endif
        end else begin
            if (accept) begin
                op_a   <= req_a[gidx*DATA_WIDTH +: DATA_WIDTH];
                op_b   <= req_b[gidx*DATA_WIDTH +: DATA_WIDTH];
                op_sub <= req_symbol[gidx];
                op_id  <= gidx;
                rr_ptr <= (gidx == ID_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= EXEC;
                        busy  <= 1'b1;
                    end
                end
                EXEC: begin
                    rsp_data  <= add_y;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
`ifdef FP_ARB_FLAGS_EN
                    rsp_flags <= {fp_is_nan(add_f), fp_is_inf(add_f)};
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (accept) begin
                            state <= EXEC;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Directed-vector bench for fp_addsub_arbiter; define FP_ARB_FLAGS_EN to also
// check rsp_flags.
module tb_fp_addsub_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned NR = 4;
    localparam int unsigned IW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [NR*DW-1:0] req_a;
    logic [NR*DW-1:0] req_b;
    logic [NR-1:0]    req_symbol;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IW-1:0]    rsp_id;
    logic [DW-1:0]    rsp_data;
    logic             busy;
`ifdef FP_ARB_FLAGS_EN
    logic [1:0]       rsp_flags;
`endif

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    logic [31:0] rr_a   [NR] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    logic [31:0] rr_res [NR] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};

    always #5 clk = ~clk;

    fp_addsub_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .ID_W       (IW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_symbol (req_symbol),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .busy       (busy)
`ifdef FP_ARB_FLAGS_EN
        ,
        .rsp_flags  (rsp_flags)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    task automatic set_req(input int unsigned id, input logic [31:0] a, input logic [31:0] b,
                           input logic sym);
        req_a[id*DW +: DW]  = a;
        req_b[id*DW +: DW]  = b;
        req_symbol[id]      = sym;
        req_valid[id]       = 1'b1;
    endtask

    task automatic load_rr_table();
        for (int i = 0; i < NR; i++) begin
            req_a[i*DW +: DW] = rr_a[i];
            req_b[i*DW +: DW] = 32'h3F800000;
            req_symbol[i]     = 1'b0;
        end
    endtask

    // one isolated op: grant in IDLE, EXEC next cycle, response the cycle after
    task automatic run_single(input string name, input int unsigned id,
                              input logic [31:0] a, input logic [31:0] b, input logic sym,
                              input logic [31:0] exp_data, input logic want_nan,
                              input logic [1:0] exp_flags);
        @(negedge clk);
        rsp_ready = 1'b1;
        set_req(id, a, b, sym);
        #1;
        check({name, "_ready"}, 32'(req_ready), 32'(1 << id));
        @(negedge clk);
        req_valid = '0;
        check({name, "_exec_valid"}, 32'(rsp_valid), 32'd0);
        check({name, "_exec_busy"}, 32'(busy), 32'd1);
        @(negedge clk);
        check({name, "_valid"}, 32'(rsp_valid), 32'd1);
        check({name, "_id"}, 32'(rsp_id), id);
        if (want_nan) begin
            check({name, "_isnan"}, 32'(is_nan(rsp_data)), 32'd1);
        end else begin
            check({name, "_data"}, rsp_data, exp_data);
        end
`ifdef FP_ARB_FLAGS_EN
        check({name, "_flags"}, 32'(rsp_flags), 32'(exp_flags));
`else
        if (exp_flags > 2'd2) $display("unexpected flag code %0d", exp_flags);
`endif
        @(negedge clk);
        check({name, "_idle_valid"}, 32'(rsp_valid), 32'd0);
        check({name, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        rsp_ready  = 1'b0;
        req_valid  = '1;
        req_symbol = '0;
        req_a      = '0;
        req_b      = '0;
        load_rr_table();

        // reset state, with every requester already asking
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_id", 32'(rsp_id), 32'd0);
        check("rst_data", rsp_data, 32'd0);
`ifdef FP_ARB_FLAGS_EN
        check("rst_flags", 32'(rsp_flags), 32'd0);
`endif

        // all four valid: grants 0,1,2,3,0 with one response every two cycles
        rst       = 1'b0;
        rsp_ready = 1'b1;
        #1;
        check("rr_first_ready", 32'(req_ready), 32'b0001);
        for (int r = 0; r < 5; r++) begin
            @(negedge clk);
            check($sformatf("rr%0d_exec_valid", r), 32'(rsp_valid), 32'd0);
            check($sformatf("rr%0d_exec_ready", r), 32'(req_ready), 32'd0);
            @(negedge clk);
            check($sformatf("rr%0d_valid", r), 32'(rsp_valid), 32'd1);
            check($sformatf("rr%0d_id", r), 32'(rsp_id), 32'(r % NR));
            check($sformatf("rr%0d_data", r), rsp_data, rr_res[r % NR]);
            if (r == 4) req_valid = '0;
        end
        @(negedge clk);
        check("rr_end_busy", 32'(busy), 32'd0);

        // single requesters, add and subtract
        run_single("add_5_7", 0, 32'h40A00000, 32'h40E00000, 1'b0, 32'h41400000, 1'b0, 2'b00);
        run_single("sub_5_7", 2, 32'h40A00000, 32'h40E00000, 1'b1, 32'hC0000000, 1'b0, 2'b00);

        // backpressure: response held 5 cycles, a waiting requester is not granted
        @(negedge clk);
        rsp_ready = 1'b0;
        set_req(1, 32'h40A00000, 32'h40E00000, 1'b0);
        #1;
        check("bp_ready1", 32'(req_ready), 32'b0010);
        @(negedge clk);
        req_valid = '0;
        set_req(3, 32'h40A00000, 32'h40E00000, 1'b1);
        check("bp_exec_ready", 32'(req_ready), 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp%0d_valid", c), 32'(rsp_valid), 32'd1);
            check($sformatf("bp%0d_id", c), 32'(rsp_id), 32'd1);
            check($sformatf("bp%0d_data", c), rsp_data, 32'h41400000);
            check($sformatf("bp%0d_ready", c), 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(req_ready), 32'b1000);
        @(negedge clk);
        req_valid = '0;
        check("bp_next_exec_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        check("bp_next_valid", 32'(rsp_valid), 32'd1);
        check("bp_next_id", 32'(rsp_id), 32'd3);
        check("bp_next_data", rsp_data, 32'hC0000000);
        @(negedge clk);
        check("bp_idle_busy", 32'(busy), 32'd0);

        // edge operands
        run_single("x_minus_x", 0, 32'h406CCCCD, 32'h406CCCCD, 1'b1, 32'h00000000, 1'b0, 2'b00);
        run_single("inf_minus", 0, 32'h7F800000, 32'h406CCCCD, 1'b1, 32'h7F800000, 1'b0, 2'b01);
        run_single("inf_m_nan", 0, 32'h7F800000, 32'hFF800001, 1'b1, 32'h7FC00000, 1'b1, 2'b10);
        run_single("tie_even", 1, 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 2'b00);
        run_single("above_half", 1, 32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 1'b0, 2'b00);
        run_single("overflow", 2, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b0, 2'b01);

        // reset during EXEC discards the op and restarts the pointer at 0
        @(negedge clk);
        set_req(2, 32'h40A00000, 32'h40E00000, 1'b0);
        @(negedge clk);
        req_valid = '0;
        rst       = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_id", 32'(rsp_id), 32'd0);
        check("mid_rst_data", rsp_data, 32'd0);
        @(negedge clk);
        check("mid_rst_no_stale", 32'(rsp_valid), 32'd0);
        load_rr_table();
        req_valid = '1;
        #1;
        check("mid_rst_grant0", 32'(req_ready), 32'b0001);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        check("mid_rst_resp_valid", 32'(rsp_valid), 32'd1);
        check("mid_rst_resp_id", 32'(rsp_id), 32'd0);
        check("mid_rst_resp_data", rsp_data, 32'h40000000);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
